regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param_if.sv | 28 ++
 rtl/regfile_param.sv | 81 ++++++++
 tb/tb_regfile_param.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/regfile_param_if.sv
// Register file bus: write, dual read, clear request and status.
// Master drives requests; slave returns read data and sweep status.
interface regfile_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              WE;
  logic [ADDR_W-1:0] W1;
  logic [DATA_W-1:0] Din;
  logic              RE;
  logic [ADDR_W-1:0] num_R1;
  logic [ADDR_W-1:0] num_R2;
  logic              CLR;
  logic [DATA_W-1:0] Dout_1;
  logic [DATA_W-1:0] Dout_2;
  logic              Dout_valid;
  logic              BUSY;

  modport master (
    output WE, W1, Din, RE, num_R1, num_R2, CLR,
    input  Dout_1, Dout_2, Dout_valid, BUSY
  );

  modport slave (
    input  WE, W1, Din, RE, num_R1, num_R2, CLR,
    output Dout_1, Dout_2, Dout_valid, BUSY
  );
endinterface

// File: rtl/regfile_param.sv
// Parameterised register file with registered dual read, write-first
// bypass and a sequenced one-register-per-cycle clear sweep.
module regfile_param #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input logic            CLK,
  input logic            RST_N,
  regfile_param_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  typedef enum logic {IDLE, CLEARING} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] rf [NUM_REGS];
  logic              wr;
  logic              rd;
  logic              last;
  logic              byp1;
  logic              byp2;

  assign last = cnt == ADDR_W'(NUM_REGS - 1);
  assign byp1 = wr && (bus.W1 == bus.num_R1);
  assign byp2 = wr && (bus.W1 == bus.num_R2);
  assign bus.BUSY = state == CLEARING;

  // A clear request wins over a same-cycle write; reads still proceed.
  always_comb begin
    state_n = state;
    wr      = 1'b0;
    rd      = 1'b0;
    unique case (state)
      IDLE: begin
        rd = bus.RE;
        wr = bus.WE & ~bus.CLR;
        if (bus.CLR) state_n = CLEARING;
      end
      CLEARING: begin
        if (last) state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)              cnt <= '0;
    else if (state == IDLE) begin
      if (bus.CLR)           cnt <= '0;
    end else                 cnt <= cnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (state == CLEARING) begin
      rf[cnt] <= '0;
    end else if (wr) begin
      rf[bus.W1] <= bus.Din;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.Dout_1     <= '0;
      bus.Dout_2     <= '0;
      bus.Dout_valid <= 1'b0;
    end else begin
      bus.Dout_valid <= rd;
      if (rd) begin
        bus.Dout_1 <= byp1 ? bus.Din : rf[bus.num_R1];
        bus.Dout_2 <= byp2 ? bus.Din : rf[bus.num_R2];
      end
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed table, corner sequences,
// random traffic against a behavioural model, and a 32x4 build.
module tb_regfile_param;
  logic clk;
  logic rst_n;

  regfile_param_if #(.DATA_W(16), .ADDR_W(3)) bus ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(2)) bus2 ();

  regfile_param #(.DATA_W(16), .NUM_REGS(8)) dut (
    .CLK(clk), .RST_N(rst_n), .bus(bus.slave)
  );

  regfile_param #(.DATA_W(32), .NUM_REGS(4)) dut2 (
    .CLK(clk), .RST_N(rst_n), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_rf [8];
  logic [15:0] m_d1;
  logic [15:0] m_d2;
  logic        m_v;
  int          m_left;

  typedef struct {
    logic        we;
    logic [2:0]  w1;
    logic [15:0] din;
    logic        re;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic        clr;
    logic [15:0] e1;
    logic [15:0] e2;
    logic        ev;
    logic        eb;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_d1 = '0; m_d2 = '0; m_v = 1'b0; m_left = 0;
  endtask

  // Drive one cycle from a negedge, advance the model, compare at next negedge.
  task automatic step(input logic we, input logic [2:0] w1,
                      input logic [15:0] din, input logic re,
                      input logic [2:0] r1, input logic [2:0] r2,
                      input logic clr);
    bus.WE = we; bus.W1 = w1; bus.Din = din;
    bus.RE = re; bus.num_R1 = r1; bus.num_R2 = r2; bus.CLR = clr;
    if (m_left > 0) begin
      m_rf[8 - m_left] = '0;
      m_left--;
      m_v = 1'b0;
    end else begin
      if (re) begin
        m_d1 = (we && !clr && w1 == r1) ? din : m_rf[r1];
        m_d2 = (we && !clr && w1 == r2) ? din : m_rf[r2];
      end
      m_v = re;
      if (clr)     m_left = 8;
      else if (we) m_rf[w1] = din;
    end
    @(posedge clk);
    @(negedge clk);
    check("model_dout1", 32'(bus.Dout_1), 32'(m_d1));
    check("model_dout2", 32'(bus.Dout_2), 32'(m_d2));
    check("model_valid", 32'(bus.Dout_valid), 32'(m_v));
    check("model_busy", 32'(bus.BUSY), 32'(m_left > 0));
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  // Counts cycles with BUSY high, poking WE and a stray CLR mid-sweep.
  task automatic count_busy(input string nm, input int seen, input int exp_w);
    int w;
    int guard;
    w = seen;
    guard = 0;
    while (bus.BUSY && guard < 40) begin
      step(1'b1, 3'(guard), 16'h5A5A, 1'b1, 3'd2, 3'd3, guard == 3);
      if (bus.BUSY) w++;
      guard++;
    end
    check(nm, 32'(w), 32'(exp_w));
  endtask

  initial begin
    int w2;
    bus.WE = 0; bus.W1 = 0; bus.Din = 0; bus.RE = 0;
    bus.num_R1 = 0; bus.num_R2 = 0; bus.CLR = 0;
    bus2.WE = 0; bus2.W1 = 0; bus2.Din = 0; bus2.RE = 0;
    bus2.num_R1 = 0; bus2.num_R2 = 0; bus2.CLR = 0;
    model_reset();

    tbl[0] = '{1'b1, 3'd3, 16'hA5A5, 1'b0, 3'd0, 3'd0, 1'b0,
               16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 3'd0, 1'b0,
               16'hA5A5, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 3'd5, 16'h1234, 1'b1, 3'd5, 3'd5, 1'b0,
               16'h1234, 16'h1234, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd1, 3'd1, 1'b0,
               16'h1234, 16'h1234, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd5, 3'd3, 1'b0,
               16'h1234, 16'hA5A5, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 3'd0, 16'h0BAD, 1'b1, 3'd0, 3'd1, 1'b0,
               16'h0BAD, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 3'd7, 16'hFFFF, 1'b1, 3'd7, 3'd7, 1'b0,
               16'hFFFF, 16'hFFFF, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 3'd2, 16'h00FF, 1'b1, 3'd2, 3'd3, 1'b1,
               16'h0000, 16'hA5A5, 1'b1, 1'b1};

    rst_n = 1'b0;
    #12;
    check("rst_dout1", 32'(bus.Dout_1), 32'h0);
    check("rst_dout2", 32'(bus.Dout_2), 32'h0);
    check("rst_valid", 32'(bus.Dout_valid), 32'h0);
    check("rst_busy", 32'(bus.BUSY), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; first row lands on the first edge after release.
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].we, tbl[i].w1, tbl[i].din, tbl[i].re,
           tbl[i].r1, tbl[i].r2, tbl[i].clr);
      check($sformatf("tbl%0d_d1", i), 32'(bus.Dout_1), 32'(tbl[i].e1));
      check($sformatf("tbl%0d_d2", i), 32'(bus.Dout_2), 32'(tbl[i].e2));
      check($sformatf("tbl%0d_v", i), 32'(bus.Dout_valid), 32'(tbl[i].ev));
      check($sformatf("tbl%0d_busy", i), 32'(bus.BUSY), 32'(tbl[i].eb));
    end

    count_busy("conflict_busy_width", 1, 8);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd7, 1'b0);
    check("conflict_reg2", 32'(bus.Dout_1), 32'h0);
    check("conflict_reg7", 32'(bus.Dout_2), 32'h0);

    for (int i = 0; i < 8; i++) step(1'b1, 3'(i), 16'hFFFF, 1'b0, 3'd0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd6, 1'b1);
    check("fill_read_d1", 32'(bus.Dout_1), 32'hFFFF);
    count_busy("sweep_busy_width", 1, 8);
    for (int i = 0; i < 8; i += 2) begin
      step(1'b0, 3'd0, 16'h0, 1'b1, 3'(i), 3'(i + 1), 1'b0);
      check($sformatf("swept_r%0d", i), 32'(bus.Dout_1), 32'h0);
      check($sformatf("swept_r%0d", i + 1), 32'(bus.Dout_2), 32'h0);
    end

    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom),
           3'($urandom), 3'($urandom), $urandom_range(0, 39) == 0);
    end
    for (int n = 0; n < 10 && bus.BUSY; n++) idle();

    step(1'b1, 3'd7, 16'h7777, 1'b1, 3'd7, 3'd7, 1'b0);
    check("pre_rst_d1", 32'(bus.Dout_1), 32'h7777);
    step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 1'b1);
    idle();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.BUSY), 32'h0);
    check("midrst_valid", 32'(bus.Dout_valid), 32'h0);
    check("midrst_d1", 32'(bus.Dout_1), 32'h0);
    check("midrst_d2", 32'(bus.Dout_2), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 3'd6, 1'b0);
    check("postrst_r7", 32'(bus.Dout_1), 32'h0);
    check("postrst_valid", 32'(bus.Dout_valid), 32'h1);
    idle();
    check("postrst_idle", 32'(bus.BUSY), 32'h0);

    // 32-bit x 4 build.
    bus2.WE = 1; bus2.W1 = 2'd3; bus2.Din = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    bus2.WE = 0; bus2.RE = 1; bus2.num_R1 = 2'd3; bus2.num_R2 = 2'd3;
    @(posedge clk); @(negedge clk);
    check("p32_d1", bus2.Dout_1, 32'hDEADBEEF);
    check("p32_d2", bus2.Dout_2, 32'hDEADBEEF);
    check("p32_valid", 32'(bus2.Dout_valid), 32'h1);
    bus2.RE = 0; bus2.CLR = 1;
    @(posedge clk); @(negedge clk);
    bus2.CLR = 0;
    w2 = 0;
    for (int n = 0; n < 20 && bus2.BUSY; n++) begin
      w2++;
      @(posedge clk); @(negedge clk);
    end
    check("p32_busy_width", 32'(w2), 32'd4);
    bus2.RE = 1;
    @(posedge clk); @(negedge clk);
    check("p32_cleared", bus2.Dout_1, 32'h0);
    bus2.RE = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
